// File: rtl/mem_write_checker_pkg.sv
// Shared types and helpers for the data-memory write checker.
package mem_write_checker_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PASS,
        FAIL
    } state_t;

    typedef enum logic [1:0] {
        FC_NONE,
        FC_ADDR,
        FC_DATA,
        FC_TIMEOUT
    } fail_code_t;

    // Counter width for a limit, never narrower than one bit so LIMIT=0 still elaborates.
    function automatic int count_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/mem_write_checker_cycle_timer.sv
// Saturating RUN-cycle counter; pulses expired on the last allowed cycle.
module cycle_timer
    import mem_write_checker_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int LIMIT = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [WIDTH-1:0] LAST  = WIDTH'((LIMIT > 0) ? LIMIT - 1 : 0);
    localparam logic [WIDTH-1:0] SAT   = '1;

    logic [WIDTH-1:0] count_q;

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable && (count_q != SAT)) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    assign expired = (LIMIT > 0) && enable && (count_q == LAST);

endmodule

// File: rtl/mem_write_checker.sv
// Pass/fail monitor for an ordered list of expected data-memory writes with a timeout.
module mem_write_checker
    import mem_write_checker_pkg::*;
#(
    parameter int NUM_CHECKS     = 4,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 1250,
    parameter int STRICT         = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enable,
    input  logic                           restart,
    input  logic                           mem_write,
    input  logic [ADDR_W-1:0]              data_adr,
    input  logic [DATA_W-1:0]              write_data,
    input  logic [NUM_CHECKS*ADDR_W-1:0]   exp_addr,
    input  logic [NUM_CHECKS*DATA_W-1:0]   exp_data,
    output logic                           done,
    output logic                           pass,
    output logic                           fail,
    output logic [1:0]                     fail_code,
    output logic [$clog2(NUM_CHECKS+1)-1:0] check_idx,
    output logic [ADDR_W-1:0]              fail_addr,
    output logic [DATA_W-1:0]              fail_data
);

    localparam int IDX_W = $clog2(NUM_CHECKS + 1);
    localparam int CNT_W = count_width(TIMEOUT_CYCLES);

    state_t             state_q;
    fail_code_t         fail_code_q;
    logic [IDX_W-1:0]   check_idx_q;
    logic [ADDR_W-1:0]  fail_addr_q;
    logic [DATA_W-1:0]  fail_data_q;
    logic               done_q;
    logic               pass_q;
    logic               fail_q;

    int                 entry;
    logic [ADDR_W-1:0]  exp_addr_sel;
    logic [DATA_W-1:0]  exp_data_sel;
    logic               addr_hit;
    logic               data_hit;
    logic               is_last;
    logic               timeout;

    // check_idx reaches NUM_CHECKS only in PASS; clamp so the select never leaves the vector.
    // NOTE: every signal in this always_comb is assigned on every path, so no latch is inferred.
    always_comb begin
        entry        = (int'(check_idx_q) < NUM_CHECKS) ? int'(check_idx_q) : 0;
        exp_addr_sel = exp_addr[entry*ADDR_W +: ADDR_W];
        exp_data_sel = exp_data[entry*DATA_W +: DATA_W];
        addr_hit     = (data_adr == exp_addr_sel);
        data_hit     = (write_data == exp_data_sel);
        is_last      = (entry == NUM_CHECKS - 1);
    end

    cycle_timer #(
        .WIDTH (CNT_W),
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (state_q != RUN),
        .enable  (state_q == RUN),
        .expired (timeout)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            fail_code_q <= FC_NONE;
            check_idx_q <= '0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (enable) state_q <= RUN;
                end
                RUN: begin
                    // A completing match beats the timeout; a mismatch reports its own code.
                    if (mem_write && addr_hit && data_hit) begin
                        check_idx_q <= check_idx_q + IDX_W'(1);
                        if (is_last) begin
                            state_q <= PASS;
                            done_q  <= 1'b1;
                            pass_q  <= 1'b1;
                        end else if (timeout) begin
                            state_q     <= FAIL;
                            done_q      <= 1'b1;
                            fail_q      <= 1'b1;
                            fail_code_q <= FC_TIMEOUT;
                        end
                    end else if (mem_write && addr_hit) begin
                        state_q     <= FAIL;
                        done_q      <= 1'b1;
                        fail_q      <= 1'b1;
                        fail_code_q <= FC_DATA;
                        fail_addr_q <= data_adr;
                        fail_data_q <= write_data;
                    end else if (mem_write && (STRICT != 0)) begin
                        state_q     <= FAIL;
                        done_q      <= 1'b1;
                        fail_q      <= 1'b1;
                        fail_code_q <= FC_ADDR;
                        fail_addr_q <= data_adr;
                        fail_data_q <= write_data;
                    end else if (timeout) begin
                        state_q     <= FAIL;
                        done_q      <= 1'b1;
                        fail_q      <= 1'b1;
                        fail_code_q <= FC_TIMEOUT;
                    end
                end
                PASS, FAIL: begin
                    if (restart) begin
                        state_q     <= RUN;
                        fail_code_q <= FC_NONE;
                        check_idx_q <= '0;
                        fail_addr_q <= '0;
                        fail_data_q <= '0;
                        done_q      <= 1'b0;
                        pass_q      <= 1'b0;
                        fail_q      <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign done      = done_q;
    assign pass      = pass_q;
    assign fail      = fail_q;
    assign fail_code = fail_code_q;
    assign check_idx = check_idx_q;
    assign fail_addr = fail_addr_q;
    assign fail_data = fail_data_q;

endmodule

// File: tb/tb_mem_write_checker.sv
// Self-checking bench: three checker configurations against a behavioural scoreboard model.
module tb_mem_write_checker;

    localparam int N = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Per-instance drivers: A = 1 check / timeout 16, B = 2 checks strict, C = 2 checks lenient.
    logic        en [N];
    logic        rs [N];
    logic        mw [N];
    logic [31:0] adr[N];
    logic [31:0] dat[N];

    logic        o_done [N];
    logic        o_pass [N];
    logic        o_fail [N];
    logic [1:0]  o_code [N];
    logic [31:0] o_faddr[N];
    logic [31:0] o_fdata[N];
    logic [1:0]  o_idx  [N];
    logic        idx_a;
    logic [1:0]  idx_b, idx_c;

    assign o_idx[0] = {1'b0, idx_a};
    assign o_idx[1] = idx_b;
    assign o_idx[2] = idx_c;

    int          cfg_n     [N] = '{1, 2, 2};
    int          cfg_strict[N] = '{1, 1, 0};
    int          cfg_tmo   [N] = '{16, 1250, 1250};
    logic [31:0] ea[N][2] = '{'{32'd252, 32'd0}, '{32'd100, 32'd252}, '{32'd100, 32'd252}};
    logic [31:0] ed[N][2] = '{'{32'h1000, 32'd0}, '{32'd5, 32'h1000}, '{32'd5, 32'h1000}};
    string       tag[N]   = '{"A", "B", "C"};

    mem_write_checker #(
        .NUM_CHECKS(1), .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16), .STRICT(1)
    ) dut_a (
        .clk(clk), .reset(reset), .enable(en[0]), .restart(rs[0]), .mem_write(mw[0]),
        .data_adr(adr[0]), .write_data(dat[0]),
        .exp_addr(32'd252), .exp_data(32'h1000),
        .done(o_done[0]), .pass(o_pass[0]), .fail(o_fail[0]), .fail_code(o_code[0]),
        .check_idx(idx_a), .fail_addr(o_faddr[0]), .fail_data(o_fdata[0])
    );

    mem_write_checker #(
        .NUM_CHECKS(2), .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(1250), .STRICT(1)
    ) dut_b (
        .clk(clk), .reset(reset), .enable(en[1]), .restart(rs[1]), .mem_write(mw[1]),
        .data_adr(adr[1]), .write_data(dat[1]),
        .exp_addr({32'd252, 32'd100}), .exp_data({32'h1000, 32'd5}),
        .done(o_done[1]), .pass(o_pass[1]), .fail(o_fail[1]), .fail_code(o_code[1]),
        .check_idx(idx_b), .fail_addr(o_faddr[1]), .fail_data(o_fdata[1])
    );

    mem_write_checker #(
        .NUM_CHECKS(2), .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(1250), .STRICT(0)
    ) dut_c (
        .clk(clk), .reset(reset), .enable(en[2]), .restart(rs[2]), .mem_write(mw[2]),
        .data_adr(adr[2]), .write_data(dat[2]),
        .exp_addr({32'd252, 32'd100}), .exp_data({32'h1000, 32'd5}),
        .done(o_done[2]), .pass(o_pass[2]), .fail(o_fail[2]), .fail_code(o_code[2]),
        .check_idx(idx_c), .fail_addr(o_faddr[2]), .fail_data(o_fdata[2])
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_on = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Scoreboard model: progress through the expected list, counted RUN cycles, verdict.
    bit          m_run  [N];
    bit          m_done [N];
    bit          m_pass [N];
    int          m_code [N];
    int          m_idx  [N];
    int          m_cyc  [N];
    logic [31:0] m_faddr[N];
    logic [31:0] m_fdata[N];

    function automatic void model_clear(input int k);
        m_run[k] = 0; m_done[k] = 0; m_pass[k] = 0; m_code[k] = 0;
        m_idx[k] = 0; m_cyc[k] = 0; m_faddr[k] = '0; m_fdata[k] = '0;
    endfunction

    function automatic void model_verdict(input int k, input bit ok, input int code,
                                          input logic [31:0] a, input logic [31:0] d);
        m_run[k] = 0; m_done[k] = 1; m_pass[k] = ok; m_code[k] = code;
        m_faddr[k] = a; m_fdata[k] = d;
    endfunction

    function automatic void model_step(input int k);
        bit last_cycle;
        bit addr_ok;
        if (m_done[k]) begin
            if (rs[k]) begin
                model_clear(k);
                m_run[k] = 1;
            end
        end else if (!m_run[k]) begin
            if (en[k]) begin
                m_run[k] = 1;
                m_cyc[k] = 0;
            end
        end else begin
            last_cycle = (cfg_tmo[k] != 0) && (m_cyc[k] == cfg_tmo[k] - 1);
            addr_ok    = mw[k] && (adr[k] == ea[k][m_idx[k]]);
            if (addr_ok && dat[k] == ed[k][m_idx[k]]) begin
                m_idx[k]++;
                if (m_idx[k] == cfg_n[k]) model_verdict(k, 1, 0, '0, '0);
                else if (last_cycle)      model_verdict(k, 0, 3, '0, '0);
            end else if (addr_ok) begin
                model_verdict(k, 0, 2, adr[k], dat[k]);
            end else if (mw[k] && cfg_strict[k] != 0) begin
                model_verdict(k, 0, 1, adr[k], dat[k]);
            end else if (last_cycle) begin
                model_verdict(k, 0, 3, '0, '0);
            end
            m_cyc[k]++;
        end
    endfunction

    initial begin
        forever begin
            @(posedge clk or posedge reset);
            for (int k = 0; k < N; k++) begin
                if (reset) model_clear(k);
                else       model_step(k);
            end
        end
    end

    // Compare process: every falling edge, every instance, every output.
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_on) begin
                for (int k = 0; k < N; k++) begin
                    check({tag[k], " done"},      64'(o_done[k]),  64'(m_done[k]));
                    check({tag[k], " pass"},      64'(o_pass[k]),  64'(m_done[k] && m_pass[k]));
                    check({tag[k], " fail"},      64'(o_fail[k]),  64'(m_done[k] && !m_pass[k]));
                    check({tag[k], " fail_code"}, 64'(o_code[k]),  64'(m_code[k]));
                    check({tag[k], " check_idx"}, 64'(o_idx[k]),   64'(m_idx[k]));
                    check({tag[k], " fail_addr"}, 64'(o_faddr[k]), 64'(m_faddr[k]));
                    check({tag[k], " fail_data"}, 64'(o_fdata[k]), 64'(m_fdata[k]));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic put_write(input int k, input logic [31:0] a, input logic [31:0] d);
        mw[k] = 1'b1; adr[k] = a; dat[k] = d;
    endtask

    task automatic idle_bus();
        for (int k = 0; k < N; k++) begin
            mw[k] = 1'b0; en[k] = 1'b0; rs[k] = 1'b0;
        end
    endtask

    initial begin
        reset = 1'b1;
        for (int k = 0; k < N; k++) begin
            adr[k] = '0; dat[k] = '0;
        end
        idle_bus();
        tick();
        cmp_on = 1'b1;
        tick();
        reset = 1'b0;
        check("reset A done", 64'(o_done[0]), 64'd0);
        check("reset B idx", 64'(o_idx[1]), 64'd0);

        // A: matching single write -> PASS one cycle later.
        en[0] = 1'b1; tick(); idle_bus();
        put_write(0, 32'd252, 32'h1000); tick(); idle_bus();
        check("A match pass", 64'(o_pass[0]), 64'd1);
        check("A match done", 64'(o_done[0]), 64'd1);
        check("A match idx", 64'(o_idx[0]), 64'd1);
        check("A match code", 64'(o_code[0]), 64'd0);

        // A: restart then data mismatch, sticky for 20 cycles.
        rs[0] = 1'b1; tick(); idle_bus();
        check("A restart idx", 64'(o_idx[0]), 64'd0);
        check("A restart done", 64'(o_done[0]), 64'd0);
        put_write(0, 32'd252, 32'h0FFF); tick(); idle_bus();
        check("A data fail", 64'(o_fail[0]), 64'd1);
        check("A data code", 64'(o_code[0]), 64'd2);
        check("A data addr", 64'(o_faddr[0]), 64'd252);
        check("A data data", 64'(o_fdata[0]), 64'h0FFF);
        en[0] = 1'b1;
        repeat (20) tick();
        idle_bus();
        check("A sticky fail", 64'(o_fail[0]), 64'd1);
        check("A sticky code", 64'(o_code[0]), 64'd2);

        // A: no writes -> timeout exactly 16 cycles after entering RUN.
        rs[0] = 1'b1; tick(); idle_bus();
        repeat (15) tick();
        check("A pre-timeout fail", 64'(o_fail[0]), 64'd0);
        tick();
        check("A timeout fail", 64'(o_fail[0]), 64'd1);
        check("A timeout code", 64'(o_code[0]), 64'd3);
        check("A timeout addr", 64'(o_faddr[0]), 64'd0);

        // A: completing match on the timeout cycle wins.
        rs[0] = 1'b1; tick(); idle_bus();
        repeat (15) tick();
        put_write(0, 32'd252, 32'h1000); tick(); idle_bus();
        check("A edge pass", 64'(o_pass[0]), 64'd1);
        check("A edge fail", 64'(o_fail[0]), 64'd0);

        // B strict / C lenient: 100/5, 96/7, 252/0x1000.
        en[1] = 1'b1; en[2] = 1'b1; tick(); idle_bus();
        put_write(1, 32'd100, 32'd5); put_write(2, 32'd100, 32'd5); tick(); idle_bus();
        put_write(1, 32'd96, 32'd7);  put_write(2, 32'd96, 32'd7);  tick(); idle_bus();
        check("B addr code", 64'(o_code[1]), 64'd1);
        check("B addr idx", 64'(o_idx[1]), 64'd1);
        check("B addr faddr", 64'(o_faddr[1]), 64'd96);
        check("B addr fdata", 64'(o_fdata[1]), 64'd7);
        check("C ignored fail", 64'(o_fail[2]), 64'd0);
        put_write(1, 32'd252, 32'h1000); put_write(2, 32'd252, 32'h1000); tick(); idle_bus();
        check("C pass", 64'(o_pass[2]), 64'd1);
        check("C idx", 64'(o_idx[2]), 64'd2);
        check("B still code", 64'(o_code[1]), 64'd1);

        // Reset pulse mid-RUN clears everything; writes in IDLE are not checked.
        rs[0] = 1'b1; tick(); idle_bus();
        tick(); tick();
        #1 reset = 1'b1;
        #1;
        check("rst A idx", 64'(o_idx[0]), 64'd0);
        check("rst B fail", 64'(o_fail[1]), 64'd0);
        check("rst C pass", 64'(o_pass[2]), 64'd0);
        check("rst B faddr", 64'(o_faddr[1]), 64'd0);
        tick();
        reset = 1'b0;
        put_write(0, 32'd252, 32'h1000); tick(); idle_bus();
        check("A idle no verdict", 64'(o_done[0]), 64'd0);
        en[0] = 1'b1; tick(); idle_bus();
        put_write(0, 32'd252, 32'h1000); tick(); idle_bus();
        check("A re-enable pass", 64'(o_pass[0]), 64'd1);

        tick(); tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
